axi_lite_read_slave: RTL and testbench

- AXI4-Lite read responder. Accepts AR beats, decodes them against a parameterised address window, issues a ready/valid read request to a local backend, and returns the result on the R channel.
- Pairs with the AXI-Lite read master on the interconnect's far side and fronts register banks and small memories.
- Supports one outstanding transaction.
- Out-of-window and misaligned accesses are answered locally, without a backend access.

---
 rtl/axi_lite_pkg.sv | 33 +++
 rtl/axi_lite_read_slave_if.sv | 44 ++++
 rtl/axi_lite_read_slave.sv | 129 ++++++++++++
 tb/tb_axi_lite_read_slave.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : axi_lite_pkg                                            |
// | Description : Shared AXI4-Lite response codes, read-slave state       |
// |               encoding and address-window decode helper.              |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package axi_lite_pkg;

  localparam logic [1:0] RSP_OKAY   = 2'b00;
  localparam logic [1:0] RSP_EXOKAY = 2'b01;
  localparam logic [1:0] RSP_SLVERR = 2'b10;
  localparam logic [1:0] RSP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } rd_state_e;

  // Operands are one bit wider than any supported address so that
  // base + size - 1 cannot wrap at the top of the address space.
  function automatic logic in_window(input logic [64:0] addr,
                                     input logic [64:0] base,
                                     input logic [64:0] size);
    logic [64:0] last;
    last = base + size - 65'd1;
    return (addr >= base) && (addr <= last);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_read_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : axi_lite_read_slave_if                                  |
// | Description : AXI4-Lite AR/R channels plus the local backend          |
// |               request/response handshake of the read responder.       |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface axi_lite_read_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  s_axi_arready;
  logic                  s_axi_arvalid;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic                  s_axi_rready;
  logic                  s_axi_rvalid;
  logic [31:0]           s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_err;

  // Responder view: AXI slave on one side, backend requester on the other.
  modport slave (
    output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp,
    output req_valid, req_addr, rsp_ready,
    input  s_axi_arvalid, s_axi_araddr, s_axi_rready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Environment view: AXI master plus backend.
  modport master (
    input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp,
    input  req_valid, req_addr, rsp_ready,
    output s_axi_arvalid, s_axi_araddr, s_axi_rready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/axi_lite_read_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axi_lite_read_slave                                     |
// | Description : Single-outstanding AXI4-Lite read responder. Decodes    |
// |               AR against an address window, forwards valid reads to   |
// |               a local backend and returns data on R. Out-of-window    |
// |               and misaligned reads are answered locally.              |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module axi_lite_read_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter longint unsigned       SIZE_BYTES    = 64'd4096,
  parameter int unsigned           ERR_CNT_WIDTH = 16
) (
  input  wire                      clk,
  input  wire                      reset_n,
  axi_lite_read_slave_if.slave     bus,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  rd_state_e                state_q, state_d;
  logic                     arready_q, arready_d;
  logic                     rvalid_q, rvalid_d;
  logic                     req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0]    req_addr_q, req_addr_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic w_ar_hs;
  logic w_r_hs;
  logic w_in_win;
  logic w_aligned;

  // arready is registered, so a handshake needs both the state and the flag.
  assign w_ar_hs   = arready_q && bus.s_axi_arvalid;
  assign w_r_hs    = rvalid_q && bus.s_axi_rready;
  assign w_in_win  = in_window(65'(bus.s_axi_araddr), 65'(BASE_ADDR), 65'(SIZE_BYTES));
  assign w_aligned = (bus.s_axi_araddr[1:0] == 2'b00);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      RD_IDLE: begin
        if (w_ar_hs) begin
          if (!w_in_win) begin
            state_d = RD_RESP;
            rresp_d = RSP_DECERR;
            rdata_d = '0;
          end else if (!w_aligned) begin
            state_d = RD_RESP;
            rresp_d = RSP_SLVERR;
            rdata_d = '0;
          end else begin
            state_d    = RD_REQ;
            req_addr_d = bus.s_axi_araddr - BASE_ADDR;
          end
        end
      end
      RD_REQ: begin
        if (bus.req_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.rsp_valid) begin
          state_d = RD_RESP;
          rdata_d = bus.rsp_data;
          rresp_d = bus.rsp_err ? RSP_SLVERR : RSP_OKAY;
        end
      end
      RD_RESP: begin
        if (w_r_hs) begin
          state_d = RD_IDLE;
          if ((rresp_q != RSP_OKAY) && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase

    // Handshake outputs follow the next state so they are pure flops.
    arready_d   = (state_d == RD_IDLE);
    rvalid_d    = (state_d == RD_RESP);
    req_valid_d = (state_d == RD_REQ);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RD_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      rdata_q     <= '0;
      rresp_q     <= RSP_OKAY;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.s_axi_arready = arready_q;
  assign bus.s_axi_rvalid  = rvalid_q;
  assign bus.s_axi_rdata   = rdata_q;
  assign bus.s_axi_rresp   = rresp_q;
  assign bus.req_valid     = req_valid_q;
  assign bus.req_addr      = req_addr_q;
  assign bus.rsp_ready     = (state_q == RD_WAIT);
  assign err_count         = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_read_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_axi_lite_read_slave                                  |
// | Description : Self-checking bench for axi_lite_read_slave. One DUT    |
// |               with the default window, one with a top-of-memory       |
// |               window and a 2-bit error counter.                       |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_axi_lite_read_slave;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct packed {
    int          lat;
    int          n_req;
    int          n_rspr;
    logic [31:0] req_addr;
    logic        addr_stable;
    logic        r_stable;
    logic        ar_low;
    logic        ar_after;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        timeout;
  } obs_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] err_count0;
  logic [1:0]  err_count1;

  int   n_err;
  int   n_chk;
  int   exp_err0;
  exp_t exp_q[$];

  axi_lite_read_slave_if #(.ADDR_WIDTH(32)) b0 ();
  axi_lite_read_slave_if #(.ADDR_WIDTH(32)) b1 ();

  axi_lite_read_slave #(
    .ADDR_WIDTH(32), .BASE_ADDR(32'h0000_0000), .SIZE_BYTES(64'd4096), .ERR_CNT_WIDTH(16)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0), .err_count(err_count0)
  );

  axi_lite_read_slave #(
    .ADDR_WIDTH(32), .BASE_ADDR(32'hFFFF_F000), .SIZE_BYTES(64'd4096), .ERR_CNT_WIDTH(2)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1), .err_count(err_count1)
  );

  // Second DUT sees an always-ready backend returning a fixed word.
  assign b1.req_ready = 1'b1;
  assign b1.rsp_valid = 1'b1;
  assign b1.rsp_data  = 32'h600D_F00D;
  assign b1.rsp_err   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // One read on DUT0, with a scripted backend and R-channel stall.
  task automatic rd0(input logic [31:0] addr, input int req_stall, input int rsp_delay,
                     input int rr_delay, input logic [31:0] data, input logic err,
                     output obs_t o);
    logic started, req_hs, rsp_done, done, rv_seen;
    int   cyc, stall_cnt, dly, rr_cnt;
    started = 0; req_hs = 0; rsp_done = 0; done = 0; rv_seen = 0;
    cyc = 0; stall_cnt = 0; dly = 0; rr_cnt = 0;
    o = '0; o.addr_stable = 1'b1; o.r_stable = 1'b1; o.ar_low = 1'b1;
    b0.s_axi_araddr = addr; b0.s_axi_arvalid = 1'b1;
    b0.rsp_data = data; b0.rsp_err = err;
    for (int k = 0; k < 300 && !done; k++) begin
      if (started) begin
        cyc++;
        b0.s_axi_arvalid = 1'b0;
        if (b0.s_axi_arready) o.ar_low = 1'b0;
      end else if (b0.s_axi_arready) begin
        started = 1'b1;
      end
      if (b0.rsp_ready) o.n_rspr++;
      if (req_hs && !rsp_done) begin
        b0.rsp_valid = (dly >= rsp_delay);
        dly++;
        if (b0.rsp_valid && b0.rsp_ready) rsp_done = 1'b1;
      end else begin
        b0.rsp_valid = 1'b0;
      end
      if (b0.req_valid) begin
        if (o.n_req == 0) o.req_addr = b0.req_addr;
        else if (b0.req_addr !== o.req_addr) o.addr_stable = 1'b0;
        o.n_req++;
        b0.req_ready = (stall_cnt >= req_stall);
        stall_cnt++;
        if (b0.req_ready) req_hs = 1'b1;
      end else begin
        b0.req_ready = 1'b0;
      end
      if (b0.s_axi_rvalid) begin
        if (!rv_seen) begin
          rv_seen = 1'b1; o.lat = cyc;
          o.rdata = b0.s_axi_rdata; o.rresp = b0.s_axi_rresp;
        end else if (b0.s_axi_rdata !== o.rdata || b0.s_axi_rresp !== o.rresp) begin
          o.r_stable = 1'b0;
        end
        b0.s_axi_rready = (rr_cnt >= rr_delay);
        rr_cnt++;
        if (b0.s_axi_rready) done = 1'b1;
      end else begin
        b0.s_axi_rready = 1'b0;
      end
      @(posedge clk); #1;
    end
    b0.s_axi_arvalid = 1'b0; b0.s_axi_rready = 1'b0;
    b0.req_ready = 1'b0; b0.rsp_valid = 1'b0;
    o.ar_after = b0.s_axi_arready;
    o.timeout  = !done;
  endtask

  // One read on DUT1 with R ready as soon as R valid appears.
  task automatic rd1(input logic [31:0] addr, output logic [31:0] o_data,
                     output logic [1:0] o_resp, output int n_req,
                     output logic [31:0] o_req_addr, output logic timeout);
    logic started, done;
    started = 0; done = 0; n_req = 0; o_req_addr = '0; o_data = '0; o_resp = '0;
    b1.s_axi_araddr = addr; b1.s_axi_arvalid = 1'b1; b1.s_axi_rready = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      if (started) b1.s_axi_arvalid = 1'b0;
      else if (b1.s_axi_arready) started = 1'b1;
      if (b1.req_valid) begin
        n_req++;
        o_req_addr = b1.req_addr;
      end
      if (b1.s_axi_rvalid) begin
        o_data = b1.s_axi_rdata; o_resp = b1.s_axi_rresp;
        b1.s_axi_rready = 1'b1;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    b1.s_axi_rready = 1'b0; b1.s_axi_arvalid = 1'b0;
    timeout = !done;
  endtask

  // Pop the scoreboard entry for the read just completed and compare.
  task automatic sb_check0(input string name, input obs_t o);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL %s_sb: scoreboard empty, got data=%h resp=%b", name, o.rdata, o.rresp);
    end else begin
      e = exp_q.pop_front();
      if (o.rdata !== e.data || o.rresp !== e.resp) begin
        n_err++;
        $display("FAIL %s_sb: got data=%h resp=%b expected data=%h resp=%b", name, o.rdata, o.rresp, e.data, e.resp);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    b0.s_axi_arvalid = 1'b0; b0.s_axi_araddr = '0; b0.s_axi_rready = 1'b0;
    b0.req_ready = 1'b0; b0.rsp_valid = 1'b0; b0.rsp_data = '0; b0.rsp_err = 1'b0;
    b1.s_axi_arvalid = 1'b0; b1.s_axi_araddr = '0; b1.s_axi_rready = 1'b0;
    exp_err0 = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({b0.s_axi_arready, b0.s_axi_rvalid, b0.req_valid, b0.rsp_ready,
         b0.s_axi_rdata, b0.s_axi_rresp, b0.req_addr, err_count0} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs0: got arr=%b rv=%b reqv=%b rspr=%b rdata=%h rresp=%b reqa=%h err=%0d expected all zero",
               b0.s_axi_arready, b0.s_axi_rvalid, b0.req_valid, b0.rsp_ready, b0.s_axi_rdata,
               b0.s_axi_rresp, b0.req_addr, err_count0);
    end
    n_chk++;
    if ({b1.s_axi_arready, b1.s_axi_rvalid, b1.req_valid, b1.rsp_ready, err_count1} !== '0) begin
      n_err++; $display("FAIL reset_outputs1: got arr=%b rv=%b reqv=%b rspr=%b err=%0d expected zero",
                        b1.s_axi_arready, b1.s_axi_rvalid, b1.req_valid, b1.rsp_ready, err_count1);
    end
    reset_n = 1'b1;
    #1;
    n_chk++;
    if (b0.s_axi_arready !== 1'b0) begin
      n_err++; $display("FAIL reset_arready_pre_edge: got %b expected 0", b0.s_axi_arready);
    end
    @(posedge clk); #1;
    n_chk++;
    if (b0.s_axi_arready !== 1'b1 || b1.s_axi_arready !== 1'b1) begin
      n_err++; $display("FAIL reset_arready_first_edge: got %b/%b expected 1/1", b0.s_axi_arready, b1.s_axi_arready);
    end
  endtask

  task automatic test_basic();
    obs_t o;
    exp_q.push_back({32'hDEAD_BEEF, 2'b00});
    rd0(32'h0000_0010, 0, 0, 0, 32'hDEAD_BEEF, 1'b0, o);
    n_chk++; if (o.timeout) begin n_err++; $display("FAIL basic_timeout: got timeout=1 expected 0"); end
    n_chk++; if (o.req_addr !== 32'h10) begin n_err++; $display("FAIL basic_req_addr: got %h expected 00000010", o.req_addr); end
    n_chk++; if (o.lat != 3) begin n_err++; $display("FAIL basic_latency: got %0d expected 3", o.lat); end
    n_chk++; if (o.n_req != 1 || o.n_rspr != 1) begin n_err++; $display("FAIL basic_backend_cycles: got req=%0d rspr=%0d expected 1/1", o.n_req, o.n_rspr); end
    sb_check0("basic", o);
    n_chk++; if (err_count0 !== 16'(exp_err0)) begin n_err++; $display("FAIL basic_err_count: got %0d expected %0d", err_count0, exp_err0); end
    n_chk++; if (!o.ar_low || !o.ar_after) begin n_err++; $display("FAIL basic_arready: got low=%b after=%b expected 1/1", o.ar_low, o.ar_after); end
  endtask

  task automatic test_local_errors();
    obs_t o;
    logic [31:0] addrs [3];
    logic [1:0]  resps [3];
    addrs[0] = 32'h0000_1000; resps[0] = 2'b11;
    addrs[1] = 32'h0000_0006; resps[1] = 2'b10;
    addrs[2] = 32'h0000_2002; resps[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({32'h0, resps[i]});
      exp_err0++;
      rd0(addrs[i], 0, 0, 0, 32'hFFFF_FFFF, 1'b0, o);
      n_chk++; if (o.timeout) begin n_err++; $display("FAIL local_err%0d_timeout: got timeout=1 expected 0", i); end
      n_chk++; if (o.lat != 1) begin n_err++; $display("FAIL local_err%0d_latency: got %0d expected 1", i, o.lat); end
      n_chk++; if (o.n_req != 0 || o.n_rspr != 0) begin n_err++; $display("FAIL local_err%0d_no_backend: got req=%0d rspr=%0d expected 0/0", i, o.n_req, o.n_rspr); end
      sb_check0("local_err", o);
      n_chk++; if (err_count0 !== 16'(exp_err0)) begin n_err++; $display("FAIL local_err%0d_err_count: got %0d expected %0d", i, err_count0, exp_err0); end
    end
  endtask

  task automatic test_stall();
    obs_t o;
    exp_q.push_back({32'hA5A5_0001, 2'b00});
    rd0(32'h0000_0FFC, 5, 3, 4, 32'hA5A5_0001, 1'b0, o);
    n_chk++; if (o.timeout) begin n_err++; $display("FAIL stall_timeout: got timeout=1 expected 0"); end
    n_chk++; if (o.req_addr !== 32'hFFC || !o.addr_stable) begin n_err++; $display("FAIL stall_req_addr: got %h stable=%b expected 00000ffc stable=1", o.req_addr, o.addr_stable); end
    n_chk++; if (o.n_req != 6 || o.n_rspr != 4) begin n_err++; $display("FAIL stall_backend_cycles: got req=%0d rspr=%0d expected 6/4", o.n_req, o.n_rspr); end
    n_chk++; if (o.lat != 11) begin n_err++; $display("FAIL stall_latency: got %0d expected 11", o.lat); end
    n_chk++; if (!o.r_stable) begin n_err++; $display("FAIL stall_r_stable: got r_stable=0 expected 1"); end
    n_chk++; if (!o.ar_low || !o.ar_after) begin n_err++; $display("FAIL stall_arready: got low=%b after=%b expected 1/1", o.ar_low, o.ar_after); end
    sb_check0("stall", o);
    n_chk++; if (err_count0 !== 16'(exp_err0)) begin n_err++; $display("FAIL stall_err_count: got %0d expected %0d", err_count0, exp_err0); end
  endtask

  task automatic test_backend_err();
    obs_t o;
    exp_q.push_back({32'h0BAD_0BAD, 2'b10});
    exp_err0++;
    rd0(32'h0000_0800, 0, 1, 0, 32'h0BAD_0BAD, 1'b1, o);
    n_chk++; if (o.timeout || o.lat != 4) begin n_err++; $display("FAIL berr_latency: got %0d timeout=%b expected 4", o.lat, o.timeout); end
    sb_check0("berr", o);
    n_chk++; if (err_count0 !== 16'(exp_err0)) begin n_err++; $display("FAIL berr_err_count: got %0d expected %0d", err_count0, exp_err0); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_q.push_back({32'h1111_0000, 2'b00});
    exp_q.push_back({32'h2222_0001, 2'b00});
    rd0(32'h0000_0100, 0, 0, 0, 32'h1111_0000, 1'b0, o);
    sb_check0("b2b_first", o);
    n_chk++; if (o.ar_after !== 1'b1) begin n_err++; $display("FAIL b2b_arready_after: got %b expected 1", o.ar_after); end
    rd0(32'h0000_0104, 0, 0, 0, 32'h2222_0001, 1'b0, o);
    n_chk++; if (o.timeout || o.lat != 3 || o.req_addr !== 32'h104) begin
      n_err++; $display("FAIL b2b_second: got lat=%0d req_addr=%h timeout=%b expected 3/00000104/0", o.lat, o.req_addr, o.timeout);
    end
    sb_check0("b2b_second", o);
  endtask

  task automatic test_high_window();
    logic [31:0] d, ra;
    logic [1:0]  r;
    int          nr;
    logic        to;
    logic [31:0] eaddr [5];
    logic [1:0]  eresp [5];
    rd1(32'hFFFF_FFFC, d, r, nr, ra, to);
    n_chk++; if (to || nr != 1 || ra !== 32'h0000_0FFC) begin
      n_err++; $display("FAIL high_req_addr: got %h req=%0d timeout=%b expected 00000ffc/1/0", ra, nr, to);
    end
    n_chk++; if (d !== 32'h600D_F00D || r !== 2'b00) begin
      n_err++; $display("FAIL high_rdata: got %h/%b expected 600df00d/00", d, r);
    end
    eaddr[0] = 32'h0000_0000; eresp[0] = 2'b11;
    eaddr[1] = 32'hFFFF_F001; eresp[1] = 2'b10;
    eaddr[2] = 32'hFFFF_EFFC; eresp[2] = 2'b11;
    eaddr[3] = 32'hFFFF_FFFF; eresp[3] = 2'b10;
    eaddr[4] = 32'h7FFF_F000; eresp[4] = 2'b11;
    for (int i = 0; i < 5; i++) begin
      rd1(eaddr[i], d, r, nr, ra, to);
      n_chk++; if (to || r !== eresp[i] || d !== 32'h0 || nr != 0) begin
        n_err++; $display("FAIL high_err%0d: got resp=%b data=%h req=%0d timeout=%b expected %b/0/0/0", i, r, d, nr, to, eresp[i]);
      end
      n_chk++; if (err_count1 !== ((i + 1 > 3) ? 2'd3 : 2'(i + 1))) begin
        n_err++; $display("FAIL high_err_count%0d: got %0d expected %0d", i, err_count1, (i + 1 > 3) ? 3 : i + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen, rv_seen, reqv_seen, ar_drop;
    seen = 0; rv_seen = 0; reqv_seen = 0; ar_drop = 0;
    b0.s_axi_araddr = 32'h0000_0020; b0.s_axi_arvalid = 1'b1; b0.req_ready = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (b0.rsp_ready) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        if (b0.req_valid) b0.s_axi_arvalid = 1'b0;
      end
    end
    b0.s_axi_arvalid = 1'b0;
    n_chk++; if (!seen) begin n_err++; $display("FAIL midrst_reach_wait: got rsp_ready=0 expected 1 within bound"); end
    #3 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({b0.s_axi_arready, b0.s_axi_rvalid, b0.req_valid, b0.rsp_ready,
         b0.s_axi_rdata, b0.s_axi_rresp, b0.req_addr, err_count0} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: got arr=%b rv=%b reqv=%b rspr=%b rdata=%h rresp=%b reqa=%h err=%0d expected all zero",
               b0.s_axi_arready, b0.s_axi_rvalid, b0.req_valid, b0.rsp_ready, b0.s_axi_rdata,
               b0.s_axi_rresp, b0.req_addr, err_count0);
    end
    exp_err0 = 0;
    b0.req_ready = 1'b0; b0.rsp_valid = 1'b1; b0.rsp_data = 32'h57A1_E000; b0.rsp_err = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    n_chk++; if (b0.s_axi_arready !== 1'b0) begin n_err++; $display("FAIL midrst_arready_pre_edge: got %b expected 0", b0.s_axi_arready); end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (b0.s_axi_rvalid) rv_seen = 1'b1;
      if (b0.req_valid || b0.rsp_ready) reqv_seen = 1'b1;
      if (!b0.s_axi_arready) ar_drop = 1'b1;
    end
    b0.rsp_valid = 1'b0;
    n_chk++; if (ar_drop) begin n_err++; $display("FAIL midrst_arready_high: got arready=0 after release expected 1"); end
    n_chk++; if (rv_seen || reqv_seen) begin n_err++; $display("FAIL midrst_stale_rsp: got rvalid=%b backend=%b expected 0/0", rv_seen, reqv_seen); end
    n_chk++; if (b0.s_axi_rdata !== 32'h0 || err_count0 !== 16'(exp_err0)) begin
      n_err++; $display("FAIL midrst_state: got rdata=%h err=%0d expected 0/0", b0.s_axi_rdata, err_count0);
    end
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    test_reset();
    test_basic();
    test_local_errors();
    test_stall();
    test_backend_err();
    test_back_to_back();
    test_high_window();
    test_reset_mid();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
